// File: rtl/bpc_out_arbiter.sv
// bpc_out_arbiter: round-robin packetiser for NUM_LANES ZRL code-buffer lanes.
// Each lane buffers 64-bit coded words in a small FIFO and parks its block
// size in a one-entry slot. When a lane's block is complete, the arbiter
// emits one header beat followed by that block's data beats on a single
// 64-bit valid/ready output port.
// Optional build macro: BPC_ARB_STATS_EN adds per-lane header and overflow
// counters on ports blk_cnt_o / ovf_cnt_o.

module bpc_out_arbiter #(
   parameter int NUM_LANES  = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [64*NUM_LANES-1:0]  lane_data_i,
   input  logic [NUM_LANES-1:0]     lane_dvalid_i,
   input  logic [11*NUM_LANES-1:0]  lane_size_i,
   input  logic [NUM_LANES-1:0]     lane_svalid_i,
   output logic [NUM_LANES-1:0]     lane_ready_o,
   output logic [63:0]              out_data_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic                     out_hdr_o,
   output logic                     out_last_o,
   output logic [2:0]               out_lane_o,
   output logic                     err_o
`ifdef BPC_ARB_STATS_EN
   ,
   output logic [16*NUM_LANES-1:0]  blk_cnt_o,
   output logic [16*NUM_LANES-1:0]  ovf_cnt_o
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   // Lane index space addressable by the 3-bit lane field; unused lanes are tied off.
   localparam int ML = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]    state_reg;
   logic [2:0]    lane_reg;
   logic [2:0]    rr_reg;
   logic [10:0]   hdr_size_reg;
   logic [3:0]    wn_reg;
   logic [3:0]    beat_cnt_reg;
   logic          err_reg;

   logic [63:0]   head_data [ML];
   logic [3:0]    wn_arr    [ML];
   logic [10:0]   size_arr  [ML];
   logic [ML-1:0] eligible;
   logic [ML-1:0] dup_vec;

   logic          hdr_accept;
   logic          data_accept;
   logic          found;
   logic [2:0]    pick;
   logic [3:0]    sum;

   assign hdr_accept  = (state_reg == ST_HDR)  && out_ready_i;
   assign data_accept = (state_reg == ST_DATA) && out_ready_i;

   generate
      for (genvar gi = 0; gi < ML; gi++) begin : g_slot
         if (gi < NUM_LANES) begin : g_lane
            logic [63:0]   mem [FIFO_DEPTH];
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic [CW-1:0] free_slots;
            logic [CW-1:0] need_ext;
            logic          size_vld_reg;
            logic [10:0]   size_reg;
            logic [3:0]    words_needed;
            logic          push;
            logic          pop;
            logic          clr;

            assign push = lane_dvalid_i[gi];
            assign pop  = data_accept && (lane_reg == 3'(gi));
            assign clr  = hdr_accept  && (lane_reg == 3'(gi));

            // Word storage: written on every lane word, no reset needed for the array.
            always_ff @(posedge clk) begin
               if (push) begin
                  mem[wr_ptr_reg] <= lane_data_i[64*gi +: 64];
               end
            end

            // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  wr_ptr_reg <= '0;
                  rd_ptr_reg <= '0;
                  count_reg  <= '0;
               end else begin
                  if (push) begin
                     wr_ptr_reg <= wr_ptr_reg + AW'(1);
                  end
                  if (pop) begin
                     rd_ptr_reg <= rd_ptr_reg + AW'(1);
                  end
                  case ({push, pop})
                     2'b10:   count_reg <= count_reg + CW'(1);
                     2'b01:   count_reg <= count_reg - CW'(1);
                     default: count_reg <= count_reg;
                  endcase
               end
            end

            // One-entry size slot: a second size while occupied is dropped.
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  size_vld_reg <= 1'b0;
                  size_reg     <= '0;
               end else if (clr) begin
                  size_vld_reg <= 1'b0;
               end else if (lane_svalid_i[gi] && !size_vld_reg) begin
                  size_vld_reg <= 1'b1;
                  size_reg     <= lane_size_i[11*gi +: 11];
               end
            end

            // Words per block: ceil(size/64), with 512..513 (raw/overflow) fixed at 8.
            always_comb begin
               words_needed = 4'd0;
               if (size_reg == 11'd0) begin
                  words_needed = 4'd0;
               end else if (size_reg >= 11'd512) begin
                  words_needed = 4'd8;
               end else begin
                  words_needed = {1'b0, size_reg[8:6]} + 4'(|size_reg[5:0]);
               end
            end

            assign need_ext   = CW'(words_needed);
            assign free_slots = CW'(FIFO_DEPTH) - count_reg;

            assign eligible[gi]  = size_vld_reg && (count_reg >= need_ext);
            assign dup_vec[gi]   = lane_svalid_i[gi] && size_vld_reg;
            assign head_data[gi] = mem[rd_ptr_reg];
            assign wn_arr[gi]    = words_needed;
            assign size_arr[gi]  = size_reg;

            // Two free slots cover the word already in flight in the code buffer's
            // output register; once the block is complete the lane is held off.
            assign lane_ready_o[gi] = (free_slots >= CW'(2)) && !eligible[gi];

`ifdef BPC_ARB_STATS_EN
            logic [15:0] blk_cnt_reg;
            logic [15:0] ovf_cnt_reg;

            // Per-lane statistics, counted on header acceptance and wrapping at 16 bits.
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  blk_cnt_reg <= '0;
                  ovf_cnt_reg <= '0;
               end else if (clr) begin
                  blk_cnt_reg <= blk_cnt_reg + 16'd1;
                  if (hdr_size_reg == 11'd513) begin
                     ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
                  end
               end
            end

            assign blk_cnt_o[16*gi +: 16] = blk_cnt_reg;
            assign ovf_cnt_o[16*gi +: 16] = ovf_cnt_reg;
`endif
         end else begin : g_pad
            assign eligible[gi]  = 1'b0;
            assign dup_vec[gi]   = 1'b0;
            assign head_data[gi] = '0;
            assign wn_arr[gi]    = '0;
            assign size_arr[gi]  = '0;
         end
      end
   endgenerate

   // Round-robin search: first eligible lane at or after the pointer, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      sum   = 4'd0;
      for (int k = 0; k < NUM_LANES; k++) begin
         sum = {1'b0, rr_reg} + 4'(k);
         if (sum >= 4'(NUM_LANES)) begin
            sum = sum - 4'(NUM_LANES);
         end
         if (!found && eligible[sum[2:0]]) begin
            found = 1'b1;
            pick  = sum[2:0];
         end
      end
   end

   // Packet FSM: IDLE picks a lane, HDR emits its header, DATA drains its words.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         lane_reg     <= 3'd0;
         rr_reg       <= 3'd0;
         hdr_size_reg <= '0;
         wn_reg       <= '0;
         beat_cnt_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (found) begin
                  lane_reg     <= pick;
                  hdr_size_reg <= size_arr[pick];
                  wn_reg       <= wn_arr[pick];
                  state_reg    <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (out_ready_i) begin
                  rr_reg       <= (lane_reg == 3'(NUM_LANES - 1)) ? 3'd0 : lane_reg + 3'd1;
                  beat_cnt_reg <= wn_reg;
                  state_reg    <= (wn_reg == 4'd0) ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (out_ready_i) begin
                  beat_cnt_reg <= beat_cnt_reg - 4'd1;
                  if (beat_cnt_reg == 4'd1) begin
                     state_reg <= ST_IDLE;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Sticky size-overrun flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_reg <= 1'b0;
      end else if (|dup_vec) begin
         err_reg <= 1'b1;
      end
   end

   // Output beat; everything derives from held state, so a stall keeps it stable.
   always_comb begin
      out_data_o = '0;
      out_last_o = 1'b0;
      case (state_reg)
         ST_HDR: begin
            out_data_o = {50'd0, lane_reg, hdr_size_reg};
            out_last_o = (wn_reg == 4'd0);
         end
         ST_DATA: begin
            out_data_o = head_data[lane_reg];
            out_last_o = (beat_cnt_reg == 4'd1);
         end
         default: begin
            out_data_o = '0;
            out_last_o = 1'b0;
         end
      endcase
   end

   assign out_valid_o = (state_reg == ST_HDR) || (state_reg == ST_DATA);
   assign out_hdr_o   = (state_reg == ST_HDR);
   assign out_lane_o  = lane_reg;
   assign err_o       = err_reg;

endmodule

// File: tb/tb_bpc_out_arbiter.sv
// Directed testbench for bpc_out_arbiter (NUM_LANES=4, FIFO_DEPTH=16).
// Inputs change just after the falling edge; outputs are sampled there too.
// Build with BPC_ARB_STATS_EN defined to also check the statistics ports.

module tb_bpc_out_arbiter;

   localparam int NL = 4;
   localparam int FD = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [64*NL-1:0]  lane_data_i;
   logic [NL-1:0]     lane_dvalid_i;
   logic [11*NL-1:0]  lane_size_i;
   logic [NL-1:0]     lane_svalid_i;
   logic [NL-1:0]     lane_ready_o;
   logic [63:0]       out_data_o;
   logic              out_valid_o;
   logic              out_ready_i;
   logic              out_hdr_o;
   logic              out_last_o;
   logic [2:0]        out_lane_o;
   logic              err_o;
`ifdef BPC_ARB_STATS_EN
   logic [16*NL-1:0]  blk_cnt_o;
   logic [16*NL-1:0]  ovf_cnt_o;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bpc_out_arbiter #(.NUM_LANES(NL), .FIFO_DEPTH(FD)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .lane_data_i   (lane_data_i),
      .lane_dvalid_i (lane_dvalid_i),
      .lane_size_i   (lane_size_i),
      .lane_svalid_i (lane_svalid_i),
      .lane_ready_o  (lane_ready_o),
      .out_data_o    (out_data_o),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_hdr_o     (out_hdr_o),
      .out_last_o    (out_last_o),
      .out_lane_o    (out_lane_o),
      .err_o         (err_o)
`ifdef BPC_ARB_STATS_EN
      ,
      .blk_cnt_o     (blk_cnt_o),
      .ovf_cnt_o     (ovf_cnt_o)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] wd(input int lane, input int idx);
      return 64'hC0DE_0000_0000_0000 | (64'(lane) << 8) | 64'(idx);
   endfunction

   function automatic logic [63:0] hw(input int lane, input int size);
      return (64'(lane) << 11) | 64'(size);
   endfunction

   task automatic nxt();
      @(negedge clk);
   endtask

   // One word into a lane; the lane must be ready, so a push into a full FIFO is caught here.
   task automatic push(input int l, input int idx);
      chk($sformatf("ready_before_push_l%0d_w%0d", l, idx), 64'(lane_ready_o[l]), 64'd1);
      lane_data_i[64*l +: 64] = wd(l, idx);
      lane_dvalid_i[l] = 1'b1;
      nxt();
      lane_dvalid_i[l] = 1'b0;
   endtask

   task automatic arm_size(input int l, input int sz);
      lane_size_i[11*l +: 11] = 11'(sz);
      lane_svalid_i[l] = 1'b1;
   endtask

   task automatic strobe();
      nxt();
      lane_svalid_i = '0;
   endtask

   // Waits (bounded) for a beat, checks it, then lets it be accepted (out_ready_i=1).
   task automatic expect_beat(input string tag, input logic hdr, input logic last,
                              input int lane, input logic [63:0] data);
      int waited = 0;
      while (out_valid_o !== 1'b1 && waited < 20) begin
         nxt();
         waited++;
      end
      chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
      chk({tag, "_hdr"},   64'(out_hdr_o),   64'(hdr));
      chk({tag, "_last"},  64'(out_last_o),  64'(last));
      chk({tag, "_lane"},  64'(out_lane_o),  64'(lane));
      chk({tag, "_data"},  out_data_o,       data);
      $display("[TB] %s beat hdr=%0d last=%0d lane=%0d data=%h", tag, out_hdr_o, out_last_o,
               out_lane_o, out_data_o);
      nxt();
   endtask

   initial begin : stim
      logic [63:0] exp_data [6];
      int w;

      rst_n = 1'b0;
      lane_data_i = '0;
      lane_dvalid_i = '0;
      lane_size_i = '0;
      lane_svalid_i = '0;
      out_ready_i = 1'b1;
      repeat (3) nxt();

      // Reset state
      chk("rst_ready", 64'(lane_ready_o), 64'hF);
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_hdr",   64'(out_hdr_o),   64'd0);
      chk("rst_last",  64'(out_last_o),  64'd0);
      chk("rst_err",   64'(err_o),       64'd0);
      chk("rst_data",  out_data_o,       64'd0);
      chk("rst_lane",  64'(out_lane_o),  64'd0);
      rst_n = 1'b1;
      nxt();

      // Lane 0: 3 words, size 150 -> one idle cycle, header 0x96, 3 beats
      push(0, 0); push(0, 1); push(0, 2);
      arm_size(0, 150);
      strobe();
      chk("t1_gap", 64'(out_valid_o), 64'd0);
      nxt();
      chk("t1_hdr_latency", 64'(out_valid_o), 64'd1);
      expect_beat("t1_hdr", 1'b1, 1'b0, 0, 64'h96);
      expect_beat("t1_d0", 1'b0, 1'b0, 0, wd(0, 0));
      expect_beat("t1_d1", 1'b0, 1'b0, 0, wd(0, 1));
      expect_beat("t1_d2", 1'b0, 1'b1, 0, wd(0, 2));
      chk("t1_end", 64'(out_valid_o), 64'd0);

      // Lanes 1 and 2 complete together: lane 1 first, then lane 2
      push(1, 0); push(2, 0); push(2, 1);
      arm_size(1, 64);
      arm_size(2, 100);
      strobe();
      expect_beat("t2_l1_hdr", 1'b1, 1'b0, 1, hw(1, 64));
      expect_beat("t2_l1_d0", 1'b0, 1'b1, 1, wd(1, 0));
      chk("t2_gap", 64'(out_valid_o), 64'd0);
      expect_beat("t2_l2_hdr", 1'b1, 1'b0, 2, hw(2, 100));
      expect_beat("t2_l2_d0", 1'b0, 1'b0, 2, wd(2, 0));
      expect_beat("t2_l2_d1", 1'b0, 1'b1, 2, wd(2, 1));

      // Pointer now 3: lanes 0 and 1 together, wrap serves lane 0 first
      push(0, 3); push(1, 1);
      arm_size(0, 10);
      arm_size(1, 1);
      strobe();
      expect_beat("t2w_l0_hdr", 1'b1, 1'b0, 0, hw(0, 10));
      expect_beat("t2w_l0_d0", 1'b0, 1'b1, 0, wd(0, 3));
      expect_beat("t2w_l1_hdr", 1'b1, 1'b0, 1, hw(1, 1));
      expect_beat("t2w_l1_d0", 1'b0, 1'b1, 1, wd(1, 1));

      // Lane 3: 8 words, size 513 -> header then exactly 8 beats
      for (int i = 0; i < 8; i++) push(3, i);
      arm_size(3, 513);
      strobe();
      expect_beat("t3_hdr", 1'b1, 1'b0, 3, 64'h1A01);
      for (int i = 0; i < 8; i++) begin
         expect_beat($sformatf("t3_d%0d", i), 1'b0, (i == 7), 3, wd(3, i));
      end
      chk("t3_end", 64'(out_valid_o), 64'd0);
`ifdef BPC_ARB_STATS_EN
      chk("t3_ovf_l3", 64'(ovf_cnt_o[48 +: 16]), 64'd1);
      chk("t3_blk_l3", 64'(blk_cnt_o[48 +: 16]), 64'd1);
      chk("t3_ovf_l0", 64'(ovf_cnt_o[0 +: 16]),  64'd0);
      chk("t3_blk_l0", 64'(blk_cnt_o[0 +: 16]),  64'd2);
`endif

      // Size 0 on lane 2: a single header beat marked last
      arm_size(2, 0);
      strobe();
      expect_beat("t4_hdr", 1'b1, 1'b1, 2, hw(2, 0));
      chk("t4_no_data", 64'(out_valid_o), 64'd0);

      // Stall toggling during a 5-word packet on lane 0 (size 300)
      out_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) push(0, 10 + i);
      arm_size(0, 300);
      strobe();
      w = 0;
      while (out_valid_o !== 1'b1 && w < 20) begin
         nxt();
         w++;
      end
      exp_data[0] = hw(0, 300);
      for (int i = 0; i < 5; i++) exp_data[i+1] = wd(0, 10 + i);
      for (int b = 0; b < 6; b++) begin
         chk($sformatf("t5_b%0d_data", b), out_data_o, exp_data[b]);
         chk($sformatf("t5_b%0d_ctl", b), {61'd0, out_valid_o, out_hdr_o, out_last_o},
             {61'd0, 1'b1, (b == 0), (b == 5)});
         nxt();
         chk($sformatf("t5_b%0d_hold_data", b), out_data_o, exp_data[b]);
         chk($sformatf("t5_b%0d_hold_ctl", b), {58'd0, out_lane_o, out_valid_o, out_hdr_o, out_last_o},
             {58'd0, 3'd0, 1'b1, (b == 0), (b == 5)});
         $display("[TB] t5 beat %0d data=%h", b, out_data_o);
         out_ready_i = 1'b1;
         nxt();
         out_ready_i = 1'b0;
      end
      chk("t5_end", 64'(out_valid_o), 64'd0);
      out_ready_i = 1'b1;

      // Lane 0 ready drops once 15 words are queued (free_slots = 1)
      for (int i = 0; i < 15; i++) push(0, 20 + i);
      chk("t5_ready_drop_15", 64'(lane_ready_o[0]), 64'd0);
      chk("t5_others_ready", 64'(lane_ready_o[3:1]), 64'h7);
      chk("t5_no_pkt", 64'(out_valid_o), 64'd0);

      // Second size on lane 1 before its packet issues: err set, first block intact
      out_ready_i = 1'b0;
      push(1, 30); push(1, 31);
      arm_size(1, 100);
      strobe();
      arm_size(1, 7);
      strobe();
      chk("t6_err", 64'(err_o), 64'd1);
      out_ready_i = 1'b1;
      expect_beat("t6_hdr", 1'b1, 1'b0, 1, hw(1, 100));
      expect_beat("t6_d0", 1'b0, 1'b0, 1, wd(1, 30));
      expect_beat("t6_d1", 1'b0, 1'b1, 1, wd(1, 31));
      chk("t6_end", 64'(out_valid_o), 64'd0);
      nxt();
      chk("t6_no_phantom", 64'(out_valid_o), 64'd0);
      chk("t6_err_sticky", 64'(err_o), 64'd1);

      // Reset in the middle of a lane 2 packet
      push(2, 40); push(2, 41); push(2, 42);
      arm_size(2, 150);
      strobe();
      expect_beat("t7_hdr", 1'b1, 1'b0, 2, hw(2, 150));
      expect_beat("t7_d0", 1'b0, 1'b0, 2, wd(2, 40));
      chk("t7_mid_valid", 64'(out_valid_o), 64'd1);
      rst_n = 1'b0;
      nxt();
      chk("t7_rst_valid", 64'(out_valid_o), 64'd0);
      chk("t7_rst_ready", 64'(lane_ready_o), 64'hF);
      chk("t7_rst_err",   64'(err_o), 64'd0);
      chk("t7_rst_hdr",   64'(out_hdr_o), 64'd0);
      chk("t7_rst_last",  64'(out_last_o), 64'd0);
      chk("t7_rst_data",  out_data_o, 64'd0);
      chk("t7_rst_lane",  64'(out_lane_o), 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         nxt();
         chk($sformatf("t7_post_valid_%0d", i), 64'(out_valid_o), 64'd0);
      end
      chk("t7_post_ready", 64'(lane_ready_o), 64'hF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
